// File: rtl/sram_async_ctrl_param.sv
// Asynchronous SRAM controller: splits a host word into SRAM_DW-wide beats,
// skips fully masked beats, and times read waits and write strobes per beat.
module sram_async_ctrl_param #(
  parameter int SRAM_AW = 18,
  parameter int SRAM_DW = 16,
  parameter int WORD_W  = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [SRAM_AW-1:0]   i_ADDR,
  input  logic [WORD_W-1:0]    i_WDATA,
  input  logic [WORD_W/8-1:0]  i_BMASK,
  input  logic                 i_WREN,
  input  logic                 i_RDEN,
  output logic [WORD_W-1:0]    o_RDATA,
  output logic                 o_ACK,
  output logic                 o_BUSY,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_OE_N,
  output logic [SRAM_DW/8-1:0] SRAM_BE_N
);

  localparam int BEATS   = WORD_W / SRAM_DW;
  localparam int LANES   = SRAM_DW / 8;
  localparam int MASK_W  = WORD_W / 8;
  localparam int LOW_W   = $clog2(BEATS);
  localparam int BIDX_W  = (BEATS > 1) ? LOW_W : 1;
  localparam int WR_LEN  = WR_WAIT + 1;
  localparam int MAX_LEN = (RD_WAIT > WR_LEN) ? RD_WAIT : WR_LEN;
  localparam int WAIT_W  = $clog2(MAX_LEN + 1);

  localparam logic [SRAM_AW-1:0] BASE_MASK = ~((SRAM_AW'(1'b1) << LOW_W) - SRAM_AW'(1'b1));
  localparam logic [WAIT_W-1:0]  RD_LAST   = WAIT_W'(RD_WAIT - 1);
  localparam logic [WAIT_W-1:0]  WR_LAST   = WAIT_W'(WR_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  // Lowest beat index >= start whose byte-mask slice is non-zero; MSB flags a hit.
  function automatic logic [BIDX_W:0] find_beat(input logic [MASK_W-1:0] mask, input int start);
    logic [BIDX_W:0] res;
    res = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if ((b >= start) && (|mask[b*LANES +: LANES])) begin
        res = {1'b1, BIDX_W'(b)};
      end
    end
    return res;
  endfunction

  state_t               state_r, state_s;
  logic [BIDX_W-1:0]    beat_r, beat_s;
  logic [WAIT_W-1:0]    wait_r, wait_s;
  logic                 wr_r, wr_s;
  logic [SRAM_AW-1:0]   base_r, base_s;
  logic [MASK_W-1:0]    mask_r, mask_s;
  logic [WORD_W-1:0]    wdata_r, wdata_s;
  logic [WORD_W-1:0]    rdata_r, rdata_s;
  logic [SRAM_AW-1:0]   addr_r, addr_s;
  logic                 ce_n_r, ce_n_s;
  logic                 we_n_r, we_n_s;
  logic                 oe_n_r, oe_n_s;
  logic [LANES-1:0]     be_n_r, be_n_s;
  logic                 dq_oe_r, dq_oe_s;
  logic [SRAM_DW-1:0]   dq_out_r, dq_out_s;
  logic                 ack_r, ack_s;
  logic                 busy_r, busy_s;
  logic                 req_ok_s;
  logic                 beat_last_s;
  logic [BIDX_W:0]      first_s;
  logic [BIDX_W:0]      nxt_s;

  // Next-state logic: request acceptance, beat sequencing and read capture.
  always_comb begin
    state_s     = ST_IDLE;
    beat_s      = beat_r;
    wait_s      = wait_r;
    wr_s        = wr_r;
    base_s      = base_r;
    mask_s      = mask_r;
    wdata_s     = wdata_r;
    rdata_s     = rdata_r;
    req_ok_s    = ((state_r == ST_IDLE) || (state_r == ST_ACK)) && (i_WREN ^ i_RDEN);
    beat_last_s = wr_r ? (wait_r == WR_LAST) : (wait_r == RD_LAST);
    first_s     = find_beat(i_BMASK, 0);
    nxt_s       = find_beat(mask_r, int'(beat_r) + 32'sd1);
    case (state_r)
      ST_IDLE, ST_ACK: begin
        if (req_ok_s) begin
          wr_s    = i_WREN;
          base_s  = i_ADDR & BASE_MASK;
          mask_s  = i_BMASK;
          wdata_s = i_WREN ? i_WDATA : wdata_r;
          wait_s  = '0;
          beat_s  = first_s[BIDX_W-1:0];
          state_s = first_s[BIDX_W] ? ST_ACCESS : ST_ACK;
          // Read slices that will never be fetched are cleared up front.
          for (int b = 0; b < BEATS; b++) begin
            if (i_RDEN && !(|i_BMASK[b*LANES +: LANES])) begin
              rdata_s[b*SRAM_DW +: SRAM_DW] = '0;
            end else begin
              rdata_s[b*SRAM_DW +: SRAM_DW] = rdata_r[b*SRAM_DW +: SRAM_DW];
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (beat_last_s) begin
          wait_s = '0;
          if (!wr_r) begin
            rdata_s[beat_r*SRAM_DW +: SRAM_DW] = SRAM_DQ;
          end else begin
            rdata_s = rdata_r;
          end
          if (nxt_s[BIDX_W]) begin
            beat_s  = nxt_s[BIDX_W-1:0];
            state_s = ST_ACCESS;
          end else begin
            beat_s  = beat_r;
            state_s = ST_ACK;
          end
        end else begin
          wait_s  = wait_r + WAIT_W'(1'b1);
          state_s = ST_ACCESS;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered SRAM strobes and host status outputs.
  always_comb begin
    addr_s   = addr_r;
    ce_n_s   = 1'b1;
    we_n_s   = 1'b1;
    oe_n_s   = 1'b1;
    be_n_s   = {LANES{1'b1}};
    dq_oe_s  = 1'b0;
    dq_out_s = dq_out_r;
    ack_s    = (state_s == ST_ACK);
    busy_s   = (state_s == ST_ACCESS);
    if (state_s == ST_ACCESS) begin
      addr_s = base_s + SRAM_AW'(beat_s);
      ce_n_s = 1'b0;
      be_n_s = ~mask_s[beat_s*LANES +: LANES];
      if (wr_s) begin
        // WE_N low for the first WR_WAIT cycles, data held through the final cycle.
        we_n_s   = (wait_s < WR_LAST) ? 1'b0 : 1'b1;
        dq_oe_s  = 1'b1;
        dq_out_s = wdata_s[beat_s*SRAM_DW +: SRAM_DW];
      end else begin
        oe_n_s = 1'b0;
      end
    end else begin
      addr_s = addr_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r  <= ST_IDLE;
      beat_r   <= '0;
      wait_r   <= '0;
      wr_r     <= 1'b0;
      base_r   <= '0;
      mask_r   <= '0;
      wdata_r  <= '0;
      rdata_r  <= '0;
      addr_r   <= '0;
      ce_n_r   <= 1'b1;
      we_n_r   <= 1'b1;
      oe_n_r   <= 1'b1;
      be_n_r   <= {LANES{1'b1}};
      dq_oe_r  <= 1'b0;
      dq_out_r <= '0;
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      beat_r   <= beat_s;
      wait_r   <= wait_s;
      wr_r     <= wr_s;
      base_r   <= base_s;
      mask_r   <= mask_s;
      wdata_r  <= wdata_s;
      rdata_r  <= rdata_s;
      addr_r   <= addr_s;
      ce_n_r   <= ce_n_s;
      we_n_r   <= we_n_s;
      oe_n_r   <= oe_n_s;
      be_n_r   <= be_n_s;
      dq_oe_r  <= dq_oe_s;
      dq_out_r <= dq_out_s;
      ack_r    <= ack_s;
      busy_r   <= busy_s;
    end
  end

  assign SRAM_DQ   = dq_oe_r ? dq_out_r : {SRAM_DW{1'bz}};
  assign SRAM_ADDR = addr_r;
  assign SRAM_CE_N = ce_n_r;
  assign SRAM_WE_N = we_n_r;
  assign SRAM_OE_N = oe_n_r;
  assign SRAM_BE_N = be_n_r;
  assign o_RDATA   = rdata_r;
  assign o_ACK     = ack_r;
  assign o_BUSY    = busy_r;

endmodule

// File: tb/tb_sram_async_ctrl_param.sv
// Directed bench for sram_async_ctrl_param with a behavioural async SRAM model.
module tb_sram_async_ctrl_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        wren, rden;
  logic [31:0] rdata;
  logic        ack, busy;
  logic [17:0] s_addr;
  wire  [15:0] s_dq;
  logic        ce_n, we_n, oe_n;
  logic [1:0]  be_n;

  always #5 clk = ~clk;

  sram_async_ctrl_param dut (
    .i_clk(clk), .i_reset(rst_n), .i_ADDR(addr), .i_WDATA(wdata), .i_BMASK(bmask),
    .i_WREN(wren), .i_RDEN(rden), .o_RDATA(rdata), .o_ACK(ack), .o_BUSY(busy),
    .SRAM_ADDR(s_addr), .SRAM_DQ(s_dq), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_BE_N(be_n)
  );

  logic [15:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  int          ce_tot, we_tot, oe_tot, busy_tot;
  logic [17:0] last_addr;
  logic [1:0]  last_be;

  assign s_dq = (!ce_n && !oe_n && we_n) ? mem[s_addr[7:0]] : 16'hzzzz;

  // SRAM model write port plus cumulative strobe counters sampled at each cycle end.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (!ce_n && !we_n) begin
      for (int l = 0; l < 2; l++) begin
        if (!be_n[l]) mem[s_addr[7:0]][l*8 +: 8] <= s_dq[l*8 +: 8];
      end
    end
    if (!rst_n) begin
      ce_tot <= 0; we_tot <= 0; oe_tot <= 0; busy_tot <= 0;
      last_addr <= '0; last_be <= 2'b11;
    end else begin
      if (!ce_n) begin
        ce_tot    <= ce_tot + 1;
        last_addr <= s_addr;
        last_be   <= be_n;
      end
      if (!ce_n && !we_n) we_tot <= we_tot + 1;
      if (!ce_n && !oe_n) oe_tot <= oe_tot + 1;
      if (busy) busy_tot <= busy_tot + 1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Presents one request, then waits (bounded) for o_ACK; lat = 0 means timeout.
  task automatic run_op(input bit at_neg, input bit wr, input logic [17:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output int lat, output int dce, output int dwe,
                        output int doe, output int dbusy);
    int ce0, we0, oe0, b0;
    if (at_neg) @(negedge clk);
    wren = wr; rden = !wr; addr = a; wdata = d; bmask = m;
    ce0 = ce_tot; we0 = we_tot; oe0 = oe_tot; b0 = busy_tot;
    lat = 0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin wren = 1'b0; rden = 1'b0; end
      if (ack) begin lat = c; break; end
    end
    dce = ce_tot - ce0; dwe = we_tot - we0; doe = oe_tot - oe0; dbusy = busy_tot - b0;
  endtask

  typedef struct {
    bit          wr;
    logic [17:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    int          lat, ce, we, oe;
    logic [31:0] rd;
    logic [17:0] la;
    logic [1:0]  lb;
    logic [7:0]  m0a;
    logic [15:0] m0v;
    logic [7:0]  m1a;
    logic [15:0] m1v;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, dce, dwe, doe, dbusy, acks, ce0;
    rst_n = 1'b0; wren = 1'b0; rden = 1'b0; addr = '0; wdata = '0; bmask = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_addr", {14'h0, s_addr}, 32'h0);
    check("rst_strobes", {29'h0, ce_n, we_n, oe_n}, 32'h7);
    check("rst_be_n", {30'h0, be_n}, 32'h3);
    rst_n = 1'b1;

    preload(8'h10, 16'h1234); preload(8'h11, 16'hABCD);
    preload(8'h20, 16'h5555); preload(8'h21, 16'h6666);
    preload(8'h30, 16'h7777); preload(8'h31, 16'h8888);
    preload(8'h40, 16'hAAAA); preload(8'h41, 16'hBBBB);

    vecs[0] = '{1'b1, 18'h00005, 32'hDEADBEEF, 4'hF, 5, 4, 2, 0, 32'h00000000, 18'h05, 2'b00, 8'h04, 16'hBEEF, 8'h05, 16'hDEAD};
    vecs[1] = '{1'b0, 18'h00010, 32'h00000000, 4'hF, 5, 4, 0, 4, 32'hABCD1234, 18'h11, 2'b00, 8'h10, 16'h1234, 8'h11, 16'hABCD};
    vecs[2] = '{1'b1, 18'h00020, 32'hCAFE0000, 4'hC, 3, 2, 1, 0, 32'hABCD1234, 18'h21, 2'b00, 8'h20, 16'h5555, 8'h21, 16'hCAFE};
    vecs[3] = '{1'b1, 18'h00030, 32'h12345678, 4'h0, 1, 0, 0, 0, 32'hABCD1234, 18'h00, 2'b11, 8'h30, 16'h7777, 8'h31, 16'h8888};
    vecs[4] = '{1'b1, 18'h00040, 32'h11223344, 4'h5, 5, 4, 2, 0, 32'hABCD1234, 18'h41, 2'b10, 8'h40, 16'hAA44, 8'h41, 16'hBB22};
    vecs[5] = '{1'b0, 18'h00041, 32'h00000000, 4'h3, 3, 2, 0, 2, 32'h0000AA44, 18'h40, 2'b00, 8'h40, 16'hAA44, 8'h41, 16'hBB22};
    vecs[6] = '{1'b0, 18'h00010, 32'h00000000, 4'h0, 1, 0, 0, 0, 32'h00000000, 18'h00, 2'b11, 8'h10, 16'h1234, 8'h11, 16'hABCD};
    vecs[7] = '{1'b0, 18'h00004, 32'h00000000, 4'hF, 5, 4, 0, 4, 32'hDEADBEEF, 18'h05, 2'b00, 8'h04, 16'hBEEF, 8'h05, 16'hDEAD};

    for (int i = 0; i < 8; i++) begin
      run_op(1'b1, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].m, lat, dce, dwe, doe, dbusy);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_ce_cycles", i), dce, vecs[i].ce);
      check($sformatf("v%0d_we_cycles", i), dwe, vecs[i].we);
      check($sformatf("v%0d_oe_cycles", i), doe, vecs[i].oe);
      check($sformatf("v%0d_busy_cycles", i), dbusy, vecs[i].lat - 1);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].rd);
      check($sformatf("v%0d_mem0", i), {16'h0, mem[vecs[i].m0a]}, {16'h0, vecs[i].m0v});
      check($sformatf("v%0d_mem1", i), {16'h0, mem[vecs[i].m1a]}, {16'h0, vecs[i].m1v});
      if (vecs[i].ce > 0) begin
        check($sformatf("v%0d_last_addr", i), {14'h0, last_addr}, {14'h0, vecs[i].la});
        check($sformatf("v%0d_last_be_n", i), {30'h0, last_be}, {30'h0, vecs[i].lb});
      end
    end

    // Both request lines high for three cycles: no access, no ack, rdata untouched.
    @(negedge clk);
    wren = 1'b1; rden = 1'b1; addr = 18'h00010; bmask = 4'hF;
    ce0 = ce_tot; acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack) acks++;
    end
    wren = 1'b0; rden = 1'b0;
    check("both_ce_cycles", ce_tot - ce0, 0);
    check("both_acks", acks, 0);
    check("both_rdata", rdata, 32'hDEADBEEF);

    // Read accepted in the ACK cycle of a write.
    run_op(1'b1, 1'b1, 18'h00050, 32'h0F0E0D0C, 4'hF, lat, dce, dwe, doe, dbusy);
    check("b2b_wr_lat", lat, 5);
    run_op(1'b0, 1'b0, 18'h00050, 32'h0, 4'hF, lat, dce, dwe, doe, dbusy);
    check("b2b_rd_lat", lat, 5);
    check("b2b_rd_ce_cycles", dce, 4);
    check("b2b_rd_rdata", rdata, 32'h0F0E0D0C);

    // Reset during beat 1 of a read.
    @(negedge clk);
    rden = 1'b1; addr = 18'h00010; bmask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rden = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_ce_n", {31'h0, ce_n}, 32'h0);
    check("midrst_pre_addr", {14'h0, s_addr}, 32'h11);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_strobes", {29'h0, ce_n, we_n, oe_n}, 32'h7);
    check("midrst_be_n", {30'h0, be_n}, 32'h3);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_ack", {31'h0, ack}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_addr", {14'h0, s_addr}, 32'h0);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("midrst_no_ack", acks, 0);
    run_op(1'b1, 1'b1, 18'h00060, 32'h01020304, 4'hF, lat, dce, dwe, doe, dbusy);
    check("post_rst_wr_lat", lat, 5);
    check("post_rst_mem0", {16'h0, mem[8'h60]}, 32'h0304);
    check("post_rst_mem1", {16'h0, mem[8'h61]}, 32'h0102);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_async_ctrl_param.md
SRAM_ASYNC_CTRL_PARAM -- requirements
Module: sram_async_ctrl_param

Interface
REQ-001 SHALL have parameter SRAM_AW, default 18, SRAM address width.
REQ-002 SHALL have parameter SRAM_DW, default 16, SRAM data width; a multiple of 8.
REQ-003 SHALL have parameter WORD_W, default 32, host word width; BEATS = WORD_W/SRAM_DW, a power of 2 in {1,2,4}.
REQ-004 SHALL have parameter RD_WAIT, default 2, cycles per read beat (>=1).
REQ-005 SHALL have parameter WR_WAIT, default 1, WE_N-low cycles per write beat (>=1).
REQ-006 i_clk  in  1  clock; all state changes on rising edge.
REQ-007 i_reset  in  1  synchronous, active-low reset.
REQ-008 i_ADDR  in  SRAM_AW  SRAM half-word address; low log2(BEATS) bits ignored.
REQ-009 i_WDATA  in  WORD_W  write data; beat b = bits [b*SRAM_DW +: SRAM_DW].
REQ-010 i_BMASK  in  WORD_W/8  byte enables, 1 = enabled.
REQ-011 i_WREN / i_RDEN  in  1 each  write / read request.
REQ-012 o_RDATA  out  WORD_W  last completed read word.
REQ-013 o_ACK  out  1  one-cycle completion pulse.
REQ-014 o_BUSY  out  1  high when not in IDLE or ACK.
REQ-015 SRAM_ADDR out SRAM_AW; SRAM_DQ inout SRAM_DW; SRAM_CE_N, SRAM_WE_N, SRAM_OE_N out 1; SRAM_BE_N out SRAM_DW/8 (byte-lane enables, active-low).

Function
REQ-016 States: IDLE, ACCESS, ACK.
REQ-017 Request accepted only in IDLE or ACK, only when exactly one of i_WREN/i_RDEN is 1; both or neither -> go/stay IDLE, no SRAM access.
REQ-018 On accept: latch base = i_ADDR with low log2(BEATS) bits cleared; latch op, i_BMASK and, for writes, i_WDATA; beat index 0, wait counter 0.
REQ-019 Beat b is skipped (zero cycles) when its mask slice i_BMASK[b*SRAM_DW/8 +: SRAM_DW/8] is all zero; the skipped read slice of o_RDATA is written 0.
REQ-020 All beats skipped -> enter ACK the cycle after accept.
REQ-021 ACCESS, active beat b: SRAM_ADDR = base + b, SRAM_CE_N = 0, SRAM_BE_N = ~mask slice b.
REQ-022 Write beat: WR_WAIT+1 cycles; SRAM_DQ driven with data slice b in all cycles; SRAM_WE_N = 0 for the first WR_WAIT cycles, 1 in the last (hold cycle); SRAM_OE_N = 1.
REQ-023 Read beat: RD_WAIT cycles; SRAM_DQ = Z; SRAM_OE_N = 0, SRAM_WE_N = 1; SRAM_DQ sampled into o_RDATA slice b at the rising edge ending the last cycle.
REQ-024 After the last active beat -> ACK; o_ACK = 1 for exactly that cycle; latency from accept edge to ACK = 1 + sum of active beat lengths (defaults, full mask: write 5, read 5 cycles).
REQ-025 Requests presented during ACCESS are ignored; host holds until o_ACK.
REQ-026 Outside ACCESS: SRAM_CE_N = SRAM_WE_N = SRAM_OE_N = 1, SRAM_BE_N all 1, SRAM_DQ = Z, SRAM_ADDR holds last value.
REQ-027 o_RDATA changes only during read beats; holds across writes, idles and rejected requests.
REQ-028 Write/read never drive SRAM_DQ while SRAM_OE_N = 0.

Reset
REQ-029 i_reset = 0 at a rising edge -> state IDLE, counters 0, o_RDATA = 0, o_ACK = 0, o_BUSY = 0, SRAM_ADDR = 0, all SRAM strobes 1, SRAM_DQ = Z, regardless of operation in progress.
REQ-030 Reset mid-access aborts the access with no o_ACK; the first request after release is handled normally.

Verification (defaults: SRAM_DW=16, WORD_W=32, RD_WAIT=2, WR_WAIT=1)
REQ-031 Write i_ADDR=0x00005, i_WDATA=0xDEADBEEF, i_BMASK=4'hF -> addr 0x00004 DQ=0xBEEF WE_N 0,1; addr 0x00005 DQ=0xDEAD WE_N 0,1; o_ACK on cycle 5 after accept.
REQ-032 Read i_ADDR=0x00010, mask 4'hF, SRAM model 0x10=0x1234, 0x11=0xABCD -> OE_N=0 two cycles per beat, o_ACK cycle 5, o_RDATA=0xABCD1234.
REQ-033 Write mask 4'hC, data 0xCAFE0000 -> only addr base+1, BE_N=2'b00, DQ=0xCAFE, o_ACK cycle 3; mask 4'h0 -> no CE_N low, o_ACK cycle 1.
REQ-034 i_WREN=i_RDEN=1 for 3 cycles -> CE_N stays 1, no o_ACK, o_RDATA unchanged.
REQ-035 Read accepted in ACK cycle of previous write -> no IDLE gap, CE_N continuous, second o_ACK 5 cycles later.
REQ-036 i_reset=0 during beat 1 of a read -> next cycle all strobes 1, o_RDATA=0, no o_ACK; a subsequent write completes in 5 cycles.
